// File: rtl/apb_req_arbiter_pkg.sv
// Shared types and sizing helpers for the APB request arbiter.
//   state_e : transfer sequencer states
//   idx_w   : width of a requester index
//   cnt_w   : width of the ACCESS-phase timeout counter
package apb_req_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Counter must hold TIMEOUT_CYCLES-1; a disabled timeout still gets 1 bit.
  function automatic int cnt_w(input int t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req_i : request vector
//   ptr_i : index of the last winner; search starts at ptr_i+1 (mod N)
//   gnt_o : one-hot grant, zero when no request
//   idx_o : index of the granted requester
//   vld_o : any request present
module rr_arbiter
  import apb_req_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             vld_o
);

  int unsigned      pos;
  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    pos   = 0;
    cand  = '0;
    // Walk N slots starting just after the pointer; the pointer itself is
    // visited last so the previous winner has lowest priority.
    for (int i = 1; i <= N; i++) begin
      pos  = (int'(ptr_i) + i) % N;
      cand = IDX_W'(pos);
      if (!vld_o && req_i[cand]) begin
        vld_o       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Shares one APB master port between NB_REQ request/response requesters.
// Round-robin arbitration, SETUP/ACCESS sequencing, per-requester response
// strobe and a PREADY timeout so a hung slave cannot lock the bus.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   req_i/we_i/addr_i/wdata_i : per-requester command, held until gnt_o
//   gnt_o                 : one-hot acceptance, combinational in IDLE
//   rvalid_o/rdata_o/err_o: registered 1-cycle response, shared data/err
//   psel_o..pwdata_o      : registered APB request
//   prdata_i/pready_i/pslverr_i : APB response
module apb_req_arbiter
  import apb_req_arbiter_pkg::*;
#(
  parameter int NB_REQ         = 4,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic [NB_REQ-1:0]                        req_i,
  input  logic [NB_REQ-1:0]                        we_i,
  input  logic [NB_REQ-1:0][APB_ADDR_WIDTH-1:0]    addr_i,
  input  logic [NB_REQ-1:0][APB_DATA_WIDTH-1:0]    wdata_i,
  output logic [NB_REQ-1:0]                        gnt_o,
  output logic [NB_REQ-1:0]                        rvalid_o,
  output logic [APB_DATA_WIDTH-1:0]                rdata_o,
  output logic                                     err_o,
  output logic                                     psel_o,
  output logic                                     penable_o,
  output logic                                     pwrite_o,
  output logic [APB_ADDR_WIDTH-1:0]                paddr_o,
  output logic [APB_DATA_WIDTH-1:0]                pwdata_o,
  input  logic [APB_DATA_WIDTH-1:0]                prdata_i,
  input  logic                                     pready_i,
  input  logic                                     pslverr_i
);

  localparam int IDX_W = idx_w(NB_REQ);
  localparam int CNT_W = cnt_w(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          ptr_q, ptr_d;
  logic [IDX_W-1:0]          win_q, win_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      psel_q, psel_d;
  logic                      penable_q, penable_d;
  logic                      pwrite_q, pwrite_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [NB_REQ-1:0]         rvalid_q, rvalid_d;
  logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      err_q, err_d;

  logic [NB_REQ-1:0]         arb_gnt;
  logic [IDX_W-1:0]          arb_idx;
  logic                      arb_vld;
  logic                      timeout;

  rr_arbiter #(
    .N     (NB_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .vld_o (arb_vld)
  );

  // Fires in the TIMEOUT_CYCLES-th ACCESS cycle; pready in that cycle wins.
  assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    cnt_d     = cnt_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    rvalid_d  = '0;
    rdata_d   = rdata_q;
    err_d     = err_q;
    gnt_o     = '0;
    unique case (state_q)
      IDLE: begin
        if (arb_vld && !rst_i) begin
          gnt_o     = arb_gnt;
          win_d     = arb_idx;
          ptr_d     = arb_idx;
          // The APB registers double as the command latch.
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = we_i[arb_idx];
          paddr_d   = addr_i[arb_idx];
          pwdata_d  = wdata_i[arb_idx];
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (pready_i || timeout) begin
          psel_d          = 1'b0;
          penable_d       = 1'b0;
          rvalid_d[win_q] = 1'b1;
          err_d           = pready_i ? pslverr_i : 1'b1;
          rdata_d         = (pready_i && !pwrite_q) ? prdata_i : '0;
          cnt_d           = '0;
          state_d         = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      ptr_q     <= IDX_W'(NB_REQ - 1);
      win_q     <= '0;
      cnt_q     <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      rvalid_q  <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign psel_o    = psel_q;
  assign penable_o = penable_q;
  assign pwrite_o  = pwrite_q;
  assign paddr_o   = paddr_q;
  assign pwdata_o  = pwdata_q;
  assign rvalid_o  = rvalid_q;
  assign rdata_o   = rdata_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: directed scenarios plus a randomized run, all
// checked every cycle against a transaction-age reference model.
module tb_apb_req_arbiter;

  localparam int NB = 4;
  localparam int TO = 8;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic [NB-1:0]       req_i, we_i;
  logic [NB-1:0][31:0] addr_i, wdata_i;
  logic [NB-1:0]       gnt_o, rvalid_o;
  logic [31:0]         rdata_o;
  logic                err_o, psel_o, penable_o, pwrite_o;
  logic [31:0]         paddr_o, pwdata_o;
  logic [31:0]         prdata_i  = '0;
  logic                pready_i  = 1'b0;
  logic                pslverr_i = 1'b0;

  apb_req_arbiter #(
    .NB_REQ(NB), .APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .err_o(err_o), .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o), .prdata_i(prdata_i),
    .pready_i(pready_i), .pslverr_i(pslverr_i)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: m_stage = 0 idle, 1 setup, 2+k = k-th ACCESS cycle.
  int          m_stage = 0;
  int          m_ptr   = NB - 1;
  int          m_win   = 0;
  logic        m_psel = 1'b0, m_pen = 1'b0, m_pwrite = 1'b0, m_err = 1'b0;
  logic [31:0] m_paddr = '0, m_pwdata = '0, m_rdata = '0;
  logic [NB-1:0] m_rvalid = '0;

  // Slave behaviour knobs
  int          slave_wait = 0;
  bit          slave_err = 1'b0, slave_rand = 1'b0, slave_fix = 1'b0;
  logic [31:0] fixval = '0;

  typedef struct {
    logic [NB-1:0] rv;
    logic          err;
    logic [31:0]   rdata;
    int            acc;
  } resp_t;

  resp_t         rlog[$];
  int            glog[$];
  int            gcyc[$];
  logic [NB-1:0] last_gnt = '0;
  logic [NB-1:0] eg;
  int            cyc = 0, acc_run = 0, w, j;

  always @(negedge clk_i) begin
    cyc++;
    eg = '0;
    w  = -1;
    if (!rst_i && m_stage == 0)
      for (int i = 1; i <= NB; i++) begin
        j = (m_ptr + i) % NB;
        if (w < 0 && req_i[j]) w = j;
      end
    if (w >= 0) eg[w] = 1'b1;

    chk("gnt",    gnt_o,     eg);
    chk("psel",   psel_o,    m_psel);
    chk("penable",penable_o, m_pen);
    chk("pwrite", pwrite_o,  m_pwrite);
    chk("paddr",  paddr_o,   m_paddr);
    chk("pwdata", pwdata_o,  m_pwdata);
    chk("rvalid", rvalid_o,  m_rvalid);
    chk("rdata",  rdata_o,   m_rdata);
    chk("err",    err_o,     m_err);

    // DUT-side logs for the directed scenarios
    last_gnt = gnt_o;
    for (int i = 0; i < NB; i++)
      if (gnt_o[i]) begin glog.push_back(i); gcyc.push_back(cyc); end
    if (rst_i) acc_run = 0;
    else if (psel_o && penable_o) acc_run++;
    if (rvalid_o != '0) begin
      rlog.push_back('{rvalid_o, err_o, rdata_o, acc_run});
      acc_run = 0;
    end

    // Advance the model to what the next clock edge produces.
    if (rst_i) begin
      m_stage = 0; m_ptr = NB - 1; m_psel = 0; m_pen = 0; m_pwrite = 0;
      m_paddr = '0; m_pwdata = '0; m_rvalid = '0; m_rdata = '0; m_err = 0;
    end else begin
      m_rvalid = '0;
      if (m_stage == 0) begin
        if (w >= 0) begin
          m_win = w; m_ptr = w; m_stage = 1; m_psel = 1; m_pen = 0;
          m_pwrite = we_i[w]; m_paddr = addr_i[w]; m_pwdata = wdata_i[w];
        end
      end else if (m_stage == 1) begin
        m_stage = 2; m_pen = 1;
      end else if (pready_i || (m_stage - 2) == TO - 1) begin
        m_rvalid[m_win] = 1'b1;
        m_err   = pready_i ? pslverr_i : 1'b1;
        m_rdata = (pready_i && !m_pwrite) ? prdata_i : 32'h0;
        m_psel = 0; m_pen = 0; m_stage = 0;
      end else begin
        m_stage++;
      end
    end
  end

  // APB slave: reacts to the current transfer age.
  always @(posedge clk_i) begin
    #1;
    prdata_i = slave_fix ? fixval : $urandom;
    if (m_stage >= 2) begin
      if (slave_rand) begin
        pready_i  = ($urandom_range(2, 0) == 0);
        pslverr_i = 1'($urandom);
      end else begin
        pready_i  = ((m_stage - 2) == slave_wait);
        pslverr_i = slave_err;
      end
    end else begin
      pready_i  = 1'($urandom);
      pslverr_i = 1'($urandom);
    end
  end

  // One cycle; granted requesters either drop or re-request with a new command.
  task automatic tick(input bit rerq);
    @(posedge clk_i); #1;
    for (int i = 0; i < NB; i++)
      if (last_gnt[i]) begin
        if (rerq) begin addr_i[i] = $urandom; wdata_i[i] = $urandom; end
        else req_i[i] = 1'b0;
      end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((req_i != '0 || m_stage != 0) && n < 200) begin tick(0); n++; end
    if (n >= 200) chk("drain_timeout", 64'(m_stage), 0);
    tick(0);
  endtask

  task automatic issue(input int i, input bit we);
    req_i[i] = 1'b1; we_i[i] = we; addr_i[i] = $urandom; wdata_i[i] = $urandom;
  endtask

  task automatic chk_resp(input string tag, input int idx, input logic [NB-1:0] rv,
                          input logic er, input logic [31:0] rd, input bit use_rd,
                          input int acc);
    if (rlog.size() > idx) begin
      chk({tag, "_rv"},  rlog[idx].rv,  rv);
      chk({tag, "_err"}, rlog[idx].err, er);
      if (use_rd)   chk({tag, "_rdata"}, rlog[idx].rdata, rd);
      if (acc >= 0) chk({tag, "_acc"},   64'(rlog[idx].acc), 64'(acc));
    end else chk({tag, "_present"}, 64'(rlog.size()), 64'(idx + 1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired @%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_i = 1'b1; req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    // Round robin straight out of reset: all writing continuously.
    rst_i = 1'b0;
    glog.delete(); gcyc.delete();
    for (int i = 0; i < NB; i++) issue(i, 1'b1);
    repeat (18) tick(1);
    req_i = '0;
    drain();
    chk("rr_count", 64'(glog.size() >= 6), 1);
    for (int i = 0; i < 6 && i < glog.size(); i++) begin
      chk("rr_order", 64'(glog[i]), 64'(i % NB));
      if (i > 0) chk("rr_space", 64'(gcyc[i] - gcyc[i-1]), 3);
    end

    // Single zero-wait read from requester 2.
    slave_wait = 0; slave_err = 0; slave_fix = 1; fixval = 32'hDEAD_BEEF;
    issue(2, 1'b0); addr_i[2] = 32'h1A10_0004;
    @(negedge clk_i); chk("sr_gnt", gnt_o, 4'b0100);
    tick(0);
    @(negedge clk_i); chk("sr_psel", psel_o, 1); chk("sr_pen0", penable_o, 0);
    chk("sr_paddr", paddr_o, 32'h1A10_0004);
    tick(0);
    @(negedge clk_i); chk("sr_pen1", penable_o, 1);
    tick(0);
    @(negedge clk_i); chk("sr_rvalid", rvalid_o, 4'b0100);
    chk("sr_rdata", rdata_o, 32'hDEAD_BEEF); chk("sr_err", err_o, 0);
    drain();

    // Five wait states then slave error.
    rlog.delete(); slave_fix = 0; slave_wait = 5; slave_err = 1;
    issue(1, 1'b0);
    drain();
    chk_resp("ws", 0, 4'b0010, 1'b1, 32'h0, 1'b0, 6);

    // Timeout with no pready, then pready on the last allowed cycle.
    rlog.delete(); slave_wait = 1000; slave_err = 0;
    issue(0, 1'b0);
    drain();
    chk_resp("to", 0, 4'b0001, 1'b1, 32'h0, 1'b1, TO);
    rlog.delete(); slave_wait = TO - 1; slave_fix = 1; fixval = 32'h1234_5678;
    issue(3, 1'b0);
    drain();
    chk_resp("to_edge", 0, 4'b1000, 1'b0, 32'h1234_5678, 1'b1, TO);

    // Reset during ACCESS; pending req 0 wins over req 1 afterwards.
    rlog.delete(); slave_wait = 1000; slave_fix = 0;
    issue(0, 1'b0);
    n = 0;
    do begin tick(0); n++; end while (!(psel_o && penable_o) && n < 10);
    chk("rst_reach_access", 64'(psel_o && penable_o), 1);
    issue(0, 1'b1); issue(1, 1'b1); rst_i = 1'b1; slave_wait = 0;
    tick(0);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_psel", psel_o, 0); chk("rst_pen", penable_o, 0);
    chk("rst_rvalid", rvalid_o, 0); chk("rst_gnt", gnt_o, 4'b0001);
    drain();
    chk("rst_no_abandoned_resp", 64'(rlog.size()), 2);

    // Withdrawn request from requester 1 while busy.
    glog.delete(); rlog.delete(); slave_wait = 2;
    issue(3, 1'b1);
    tick(0);
    req_i[1] = 1'b1;
    tick(0);
    req_i[1] = 1'b0;
    issue(2, 1'b1);
    drain();
    chk("wd_gcount", 64'(glog.size()), 2);
    if (glog.size() == 2) begin
      chk("wd_g0", 64'(glog[0]), 3);
      chk("wd_g1", 64'(glog[1]), 2);
    end
    chk("wd_rcount", 64'(rlog.size()), 2);
    chk_resp("wd_r0", 0, 4'b1000, 1'b0, 32'h0, 1'b1, 3);
    chk_resp("wd_r1", 1, 4'b0100, 1'b0, 32'h0, 1'b1, 3);

    // Randomized traffic and slave timing, checked by the model.
    slave_rand = 1;
    repeat (3000) begin
      tick(0);
      for (int i = 0; i < NB; i++) begin
        if (!req_i[i] && $urandom_range(3, 0) == 0) issue(i, 1'($urandom));
        else if (req_i[i] && $urandom_range(39, 0) == 0) req_i[i] = 1'b0;
      end
    end
    req_i = '0;
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
- Shares one APB master port, which feeds the upstream slave port of the APB node, between NB_REQ simple request/response requesters (core data port, debug unit, DMA, ...).
- Arbitrates round-robin and sequences the APB SETUP and ACCESS phases.
- Returns read data and error per requester.
- Enforces a PREADY timeout so a hung peripheral cannot lock the bus.

Parameters:
- NB_REQ, 4, number of requesters (2..16).
- APB_ADDR_WIDTH, 32, address width.
- APB_DATA_WIDTH, 32, data width.
- TIMEOUT_CYCLES, 256, maximum ACCESS-phase cycles before forced error termination; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- req_i  in  NB_REQ  per-requester request; held with its command fields until gnt_o
- we_i  in  NB_REQ  1=write
- addr_i  in  NB_REQ x APB_ADDR_WIDTH  packed address array
- wdata_i  in  NB_REQ x APB_DATA_WIDTH  packed write data array
- gnt_o  out  NB_REQ  one-hot request acceptance (Mealy, valid in IDLE)
- rvalid_o  out  NB_REQ  one-hot response strobe, 1 cycle, registered
- rdata_o  out  APB_DATA_WIDTH  read data, valid with rvalid_o, shared by all requesters
- err_o  out  1  error, valid with rvalid_o (PSLVERR or timeout)
- psel_o  out  1  APB select
- penable_o  out  1  APB enable
- pwrite_o  out  1  APB write
- paddr_o  out  APB_ADDR_WIDTH  APB address
- pwdata_o  out  APB_DATA_WIDTH  APB write data
- prdata_i  in  APB_DATA_WIDTH  APB read data
- pready_i  in  1  APB ready
- pslverr_i  in  1  APB slave error

Behaviour:
- Clock and reset: one clock, clk_i; rst_i is synchronous and active-high. With rst_i high at a rising edge:
  - state goes to IDLE;
  - every registered output goes to 0: psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, rvalid_o, rdata_o, err_o;
  - the round-robin pointer goes to NB_REQ-1, so req 0 has top priority first;
  - the timeout counter goes to 0.
  A transfer in flight is abandoned without a response; gnt_o is 0 while rst_i is high.
- FSM, states IDLE, SETUP, ACCESS:
  - IDLE: if req_i is nonzero, the winner is the first set bit searching upward from pointer+1, modulo NB_REQ.
    - gnt_o[winner]=1 combinationally in that cycle.
    - Latch winner index, we, addr and wdata.
    - Pointer becomes winner; next state SETUP.
    - req_i==0 keeps IDLE with gnt_o=0.
  - SETUP (exactly 1 cycle): psel_o=1, penable_o=0, paddr, pwrite and pwdata driven from the latch. Next state ACCESS.
  - ACCESS: psel_o=1, penable_o=1, all APB outputs held stable; the counter increments each ACCESS cycle.
    - pready_i=1: next cycle rvalid_o[winner]=1, rdata_o=prdata_i (0 for writes), err_o=pslverr_i; state IDLE.
    - Timeout, pready_i=0 and the counter reaching TIMEOUT_CYCLES-1 (counter==TIMEOUT_CYCLES-1 during the ACCESS cycle): terminate the same way with err_o=1 and rdata_o=0; psel_o and penable_o drop.
    - If pready_i=1 in the cycle the timeout would fire, pready_i wins: a normal response.
- APB outputs are registered. psel_o and penable_o are 0 in IDLE; paddr, pwrite and pwdata keep their last values in IDLE.
- Latency and throughput:
  - Grant at cycle N, SETUP at N+1, ACCESS at N+2.
  - With zero-wait pready, rvalid_o at N+3.
  - The state is IDLE at N+3, so a new grant can coincide with rvalid_o. Sustained rate is 1 transfer per 3 cycles.
- Requester rules:
  - The requester holds req, we, addr and wdata until it sees gnt_o.
  - It may deassert req_i before grant (the request is withdrawn, no response).
  - It may re-request immediately after gnt_o; the grant is still subject to round-robin.
- Fairness: with all requesters asserting continuously, grants rotate 0,1,..,NB_REQ-1,0.
- rdata_o and err_o hold their last values between responses; rvalid_o is exactly a 1-cycle pulse.

Decomposition:
- Package apb_req_arbiter_pkg:
  - state enum {IDLE, SETUP, ACCESS};
  - localparam IDX_W=$clog2(NB_REQ) helper function;
  - timeout counter width rule $clog2(TIMEOUT_CYCLES+1).
- Sub-module rr_arbiter, combinational: inputs req vector and pointer; outputs one-hot grant and index. Reused by future arbiters.
- Top level holds the FSM, the command latch, the timeout counter and the response registers.

Test Plan:
- Single read: req 2 reads 0x1A10_0004, slave returns 0xDEAD_BEEF with zero wait. Required: psel at N+1, penable at N+2, rvalid_o=0b0100 at N+3, rdata_o=0xDEAD_BEEF, err_o=0.
- Round-robin: all 4 requesters hold writes continuously from reset. Required: grant order 0,1,2,3,0,1; each grant spaced 3 cycles; paddr and pwdata match the granted requester.
- Wait states and error: slave holds pready=0 for 5 ACCESS cycles, then pready=1 with pslverr=1. Required: APB outputs stable for 6 ACCESS cycles, rvalid with err_o=1.
- Timeout, TIMEOUT_CYCLES=8: pready is never asserted. Required: exactly 8 ACCESS cycles, psel drops, rvalid with err_o=1 and rdata_o=0. Repeat with pready=1 on the 8th ACCESS cycle: normal response, err_o=0.
- Reset mid-transfer: assert rst_i during ACCESS. Required: next cycle psel_o=0, penable_o=0, rvalid_o=0; after release, a pending req 0 is granted first.
- Withdrawn request: req 1 pulses for 1 cycle while a transfer is busy. Required: no grant and no response for req 1; the arbiter then serves other requesters normally.
